// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: issues sequential fetches over a req/ack
// handshake, queues {pc, instr} pairs, and hands them to IF/ID with
// valid/ready. A redirect flushes the queue and restarts fetch.
module fetch_buffer #(
    parameter int                 DEPTH    = 4,
    parameter int                 ADDR_W   = 64,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  pending_pc_q, pending_pc_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_d    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];

    logic              push, pop;
    logic [ADDR_W-1:0] redir_pc;

    // Outputs: head of queue, zeroed when empty; request only while a fetch is in flight
    always_comb begin
        out_valid = (count_q != '0);
        out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
        out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
        imem_req  = (state_q == WAIT) || (state_q == DISCARD);
        imem_addr = fetch_pc_q;
        count     = count_q;
    end

    // Queue bookkeeping and fetch FSM next-state; count_d feeds the credit check
    always_comb begin
        redir_pc     = redirect_pc & ~ADDR_W'(3);
        push         = (state_q == WAIT) && imem_ack && !redirect;
        pop          = out_valid && out_ready && !redirect;
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        pc_mem_d     = pc_mem_q;
        instr_mem_d  = instr_mem_q;

        // Redirect flushes everything, including a head that would have been popped
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        end

        if (push) begin
            pc_mem_d[wr_ptr_q]    = fetch_pc_q;
            instr_mem_d[wr_ptr_q] = imem_rdata;
        end

        case (state_q)
            IDLE: begin
                if (redirect)
                    fetch_pc_d = redir_pc;
                else if (count_d < CW'(DEPTH))
                    state_d = WAIT;
            end
            WAIT: begin
                if (redirect && !imem_ack) begin
                    // Request cannot be cancelled: wait out its ack in DISCARD
                    state_d      = DISCARD;
                    pending_pc_d = redir_pc;
                end else if (redirect) begin
                    fetch_pc_d = redir_pc;
                    state_d    = IDLE;
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                    if (!(count_d < CW'(DEPTH)))
                        state_d = IDLE;
                end
            end
            DISCARD: begin
                if (redirect)
                    pending_pc_d = redir_pc;
                if (imem_ack) begin
                    // Newest redirect wins if it lands on the ack cycle
                    fetch_pc_d = redirect ? redir_pc : pending_pc_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state with synchronous reset; an ack arriving under reset is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, outputs are gated by out_valid
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: streaming, backpressure, redirect in
// IDLE/WAIT/DISCARD, redirect coinciding with ack, reset mid-request, PC wrap.
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    // Memory model: either acks every request same cycle with rdata=addr, or is driven by hand
    logic        auto_ack;
    logic        man_ack;
    logic [31:0] man_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        imem_ack   = auto_ack ? imem_req : man_ack;
        imem_rdata = auto_ack ? imem_addr[31:0] : man_rdata;
    end

    fetch_buffer #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .count(count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        auto_ack = 1'b1; man_ack = 1'b0; man_rdata = '0;
        tick(); tick();
        chk("rst_req",   64'(imem_req),  64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc",    out_pc,         64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_count", 64'(count),     64'd0);

        // Streaming at one instruction per cycle
        reset = 1'b0; out_ready = 1'b1;
        tick();
        chk("t1_addr0", imem_addr, 64'h0);
        chk("t1_req0",  64'(imem_req), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_pc",    out_pc,         64'(4 * i));
            chk("t1_instr", 64'(out_instr), 64'(4 * i));
            chk("t1_count", 64'(count),     64'd1);
        end

        // Backpressure: fill to DEPTH, drain in order, fetch resumes at 0x10
        reset = 1'b1; tick();
        reset = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t2_count_full", 64'(count),    64'd4);
        chk("t2_req_full",   64'(imem_req), 64'd0);
        chk("t2_head0",      out_pc,        64'h0);
        out_ready = 1'b1;
        tick();
        chk("t2_head4",  out_pc,        64'h4);
        chk("t2_resume", imem_addr,     64'h10);
        chk("t2_reqon",  64'(imem_req), 64'd1);
        tick(); chk("t2_head8",  out_pc, 64'h8);
        tick(); chk("t2_headC",  out_pc, 64'hC);
        tick(); chk("t2_head10", out_pc, 64'h10);

        // Redirect in IDLE with a full queue (and out_ready high): flush, align to 0x100
        reset = 1'b1; tick();
        reset = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        redirect = 1'b1; redirect_pc = 64'h103; out_ready = 1'b1;
        tick();
        redirect = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
        chk("t3_count", 64'(count),     64'd0);
        chk("t3_valid", 64'(out_valid), 64'd0);
        chk("t3_pc0",   out_pc,         64'd0);
        chk("t3_req",   64'(imem_req),  64'd0);
        tick();
        chk("t3_addr", imem_addr,     64'h100);
        chk("t3_reqw", 64'(imem_req), 64'd1);
        man_ack = 1'b1; man_rdata = 32'h1111_1111;
        tick();
        man_ack = 1'b0;
        chk("t3_pushpc",    out_pc,         64'h100);
        chk("t3_pushinstr", 64'(out_instr), 64'h1111_1111);

        // Redirect while WAIT with ack delayed: DISCARD, second redirect overrides
        redirect = 1'b1; redirect_pc = 64'h200;
        tick();
        redirect = 1'b0;
        chk("t4_count", 64'(count),    64'd0);
        chk("t4_held",  imem_addr,     64'h104);
        chk("t4_req",   64'(imem_req), 64'd1);
        tick();
        chk("t4_held2", imem_addr,     64'h104);
        redirect = 1'b1; redirect_pc = 64'h300;
        tick();
        redirect = 1'b0;
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        tick();
        man_ack = 1'b0;
        chk("t4_dropvalid", 64'(out_valid), 64'd0);
        chk("t4_idle",      64'(imem_req),  64'd0);
        tick();
        chk("t4_newaddr", imem_addr,      64'h300);
        chk("t4_newreq",  64'(imem_req),  64'd1);
        chk("t4_noinstr", 64'(out_instr), 64'd0);

        // Redirect coincident with ack: data dropped, one IDLE cycle, then fetch 0x200
        man_ack = 1'b1; man_rdata = 32'hAAAA_0000;
        tick();
        chk("t5_push", out_pc, 64'h300);
        man_rdata = 32'hBBBB_0000; redirect = 1'b1; redirect_pc = 64'h200;
        tick();
        man_ack = 1'b0; redirect = 1'b0;
        chk("t5_count", 64'(count),    64'd0);
        chk("t5_idle",  64'(imem_req), 64'd0);
        tick();
        chk("t5_req",   64'(imem_req),  64'd1);
        chk("t5_addr",  imem_addr,      64'h200);
        chk("t5_valid", 64'(out_valid), 64'd0);

        // Reset during WAIT with two entries; ack under reset is ignored
        out_ready = 1'b0; man_ack = 1'b1; man_rdata = 32'h2;
        tick(); tick();
        chk("t6_count2", 64'(count), 64'd2);
        reset = 1'b1;
        tick();
        chk("t6_req",   64'(imem_req),  64'd0);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_count", 64'(count),     64'd0);
        tick();
        reset = 1'b0; man_ack = 1'b0;
        tick();
        chk("t6_addr", imem_addr,     64'h0);
        chk("t6_reqw", 64'(imem_req), 64'd1);
        man_ack = 1'b1; man_rdata = 32'h5;
        tick();
        man_ack = 1'b0;
        chk("t6_pc",    out_pc,         64'h0);
        chk("t6_instr", 64'(out_instr), 64'h5);

        // PC wrap: redirect to the top word, fetch_pc wraps to 0 after the push
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect = 1'b0; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        man_ack = 1'b1; man_rdata = 32'h77;
        tick();
        man_ack = 1'b0;
        chk("wrap_pc",    out_pc,         64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr", 64'(out_instr), 64'h77);
        chk("wrap_next",  imem_addr,      64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
